instr_encoder: RTL and testbench

Inverse of the control decoder: turns a symbolic instruction request (operation enum plus register/immediate fields) into a 32-bit MIPS instruction word carrying the exact opcode/funct values the control unit decodes. Encoded words are written sequentially into instruction memory over a request/acknowledge port. It sits between the test/boot loader and instruction memory, so programs can be built in-simulation or at boot without a hand-assembled image.

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/instr_pack.sv | 45 ++++
 rtl/instr_encoder.sv | 118 +++++++++++
 tb/tb_instr_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: operation enum, opcode/funct values and field positions.
// The opcode/funct values match what the control decoder expects.
package mips_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRLV, OP_JR,
    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_SLTI, OP_SLTIU,
    OP_J, OP_JAL
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_ADDI    = 6'b001000;
  localparam logic [5:0] OPC_ADDIU   = 6'b001001;
  localparam logic [5:0] OPC_ANDI    = 6'b001100;
  localparam logic [5:0] OPC_ORI     = 6'b001101;
  localparam logic [5:0] OPC_XORI    = 6'b001110;
  localparam logic [5:0] OPC_LUI     = 6'b001111;
  localparam logic [5:0] OPC_LW      = 6'b100011;
  localparam logic [5:0] OPC_SW      = 6'b101011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] OPC_SLTI    = 6'b001010;
  localparam logic [5:0] OPC_SLTIU   = 6'b001011;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;

  function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return (32'(OPC_SPECIAL) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
           (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
  endfunction

  function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return (32'(opc) << OPC_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) | 32'(imm);
  endfunction

  function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
    return (32'(opc) << OPC_LSB) | 32'(target);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: symbolic operation plus fields to a 32-bit MIPS word.
// Fields an operation does not use are forced to zero; unknown ops raise illegal.
module instr_pack
  import mips_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:   word = pack_r(rs, rt, rd, 5'd0, FN_ADD);
      OP_SUB:   word = pack_r(rs, rt, rd, 5'd0, FN_SUB);
      OP_XOR:   word = pack_r(rs, rt, rd, 5'd0, FN_XOR);
      OP_SLL:   word = pack_r(5'd0, rt, rd, shamt, FN_SLL);
      OP_SRLV:  word = pack_r(rs, rt, rd, 5'd0, FN_SRLV);
      OP_JR:    word = pack_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI:  word = pack_i(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = pack_i(OPC_ADDIU, rs, rt, imm);
      OP_ANDI:  word = pack_i(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = pack_i(OPC_ORI, rs, rt, imm);
      OP_XORI:  word = pack_i(OPC_XORI, rs, rt, imm);
      OP_LUI:   word = pack_i(OPC_LUI, 5'd0, rt, imm);
      OP_LW:    word = pack_i(OPC_LW, rs, rt, imm);
      OP_SW:    word = pack_i(OPC_SW, rs, rt, imm);
      OP_BEQ:   word = pack_i(OPC_BEQ, rs, rt, imm);
      OP_BNE:   word = pack_i(OPC_BNE, rs, rt, imm);
      OP_SLTI:  word = pack_i(OPC_SLTI, rs, rt, imm);
      OP_SLTIU: word = pack_i(OPC_SLTIU, rs, rt, imm);
      OP_J:     word = pack_j(OPC_J, target);
      OP_JAL:   word = pack_j(OPC_JAL, target);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes instruction requests and writes them sequentially into instruction memory
// over a req/ack port, stopping when DEPTH words have been written.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BASE   = 0,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FULL} state_e;

  state_e          state, state_next;
  logic [31:0]     word;
  logic            illegal;
  logic            accept;
  logic            do_clear;
  logic            write_done;
  logic [ADDR_W:0] count_inc;
  logic            ready_next, req_next, full_next;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

  // clear wins over a simultaneous request in IDLE; it is ignored while a write is pending
  assign do_clear   = clear && (state != S_REQ);
  assign accept     = (state == S_IDLE) && in_valid && !clear;
  assign write_done = (state == S_REQ) && mem_ack;
  assign count_inc  = count + (ADDR_W + 1)'(1);

  // State register; handshake flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      mem_req  <= 1'b0;
      full     <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= ready_next;
      mem_req  <= req_next;
      full     <= full_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept && !illegal) state_next = S_REQ;
      S_REQ:   if (mem_ack) state_next = (count_inc == (ADDR_W + 1)'(DEPTH)) ? S_FULL : S_IDLE;
      S_FULL:  if (do_clear) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_next = 1'b0;
    req_next   = 1'b0;
    full_next  = 1'b0;
    case (state_next)
      S_IDLE:  ready_next = 1'b1;
      S_REQ:   req_next   = 1'b1;
      S_FULL:  full_next  = 1'b1;
      default: ready_next = 1'b0;
    endcase
  end

  // Address, data, count and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= ADDR_W'(BASE);
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else if (do_clear) begin
      mem_addr <= ADDR_W'(BASE);
      count    <= '0;
      err      <= 1'b0;
    end else begin
      if (accept && illegal) err <= 1'b1;
      if (accept && !illegal) mem_wdata <= word;
      if (write_done) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        count    <= count_inc;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: arithmetic reference encoder, expected writes queued
// by the driver and checked by an independent memory-side monitor.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 4;

  localparam int FN[6]     = '{32, 34, 38, 0, 6, 8};
  localparam int I_OPC[12] = '{8, 9, 12, 13, 14, 15, 35, 43, 4, 5, 10, 11};

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0]       in_imm = '0;
  logic [25:0]       in_target = '0;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full, err;

  int   ack_mode = 0;
  logic man_ack = 1'b0;
  logic rnd_ack = 1'b0;

  int  checks = 0;
  int  errors = 0;
  wr_t q[$];
  int  exp_addr = 0;
  int  exp_count = 0;
  bit  exp_err = 1'b0;

  assign mem_ack = (ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? rnd_ack : man_ack;

  instr_encoder #(.ADDR_W(ADDR_W), .BASE(0), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_ack = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: field values weighted by their bit position
  function automatic logic [31:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    longint v;
    if (op <= 5) begin
      if (op == 3) rs = 0;
      if (op == 0 || op == 1 || op == 2 || op == 4) sh = 0;
      if (op == 5) begin rt = 0; rd = 0; sh = 0; end
      v = ((((longint'(rs) * 32 + rt) * 32 + rd) * 32 + sh) * 64) + FN[op];
    end else if (op <= 17) begin
      if (op == 11) rs = 0;
      v = ((longint'(I_OPC[op-6]) * 32 + rs) * 32 + rt) * 65536 + imm;
    end else begin
      v = longint'((op == 18) ? 2 : 3) * 67108864 + tgt;
    end
    return 32'(v);
  endfunction

  // Memory-side monitor: every completed write must match the head of the queue
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected",
                   mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = q.pop_front();
          if (32'(mem_addr) != 32'(e.addr) || mem_wdata != e.data) begin
            errors++;
            $display("FAIL write: got addr 0x%0h data 0x%08h expected addr 0x%0h data 0x%08h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end else if (mem_req && q.size() != 0) begin
        checks++;
        if (32'(mem_addr) != 32'(q[0].addr) || mem_wdata != q[0].data) begin
          errors++;
          $display("FAIL hold: got addr 0x%0h data 0x%08h expected addr 0x%0h data 0x%08h",
                   mem_addr, mem_wdata, q[0].addr, q[0].data);
        end
      end
    end
  end

  // Waits (bounded) until the DUT is idle on the memory side and all writes are checked
  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((mem_req || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mem_req || q.size() != 0) check("drain_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_addr  = 0;
    exp_count = 0;
    exp_err   = 1'b0;
    @(negedge clk);
    check("clear_count", count, 0);
    check("clear_addr", mem_addr, 0);
    check("clear_ready", in_ready, 1);
    check("clear_err", err, 0);
    check("clear_full", full, 0);
    @(posedge clk); #1;
  endtask

  task automatic expect_full();
    wait_drain();
    check("full_flag", full, 1);
    check("full_ready", in_ready, 0);
    check("full_count", count, DEPTH);
  endtask

  // Issues one request; expw < 0 takes the expected word from the reference model
  task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                      input int imm, input int tgt, input longint expw);
    int n = 0;
    bit ill = (op > 19);
    if (exp_count == int'(DEPTH)) begin
      expect_full();
      do_clear();
    end
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tgt);
    in_valid = 1'b1;
    if (ill) begin
      exp_err = 1'b1;
    end else begin
      wr_t e;
      e.addr = exp_addr;
      e.data = (expw < 0) ? ref_encode(op, rs, rt, rd, sh, imm, tgt) : 32'(expw);
      q.push_back(e);
      exp_addr++;
      exp_count++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("err_state", err, exp_err);
    if (ill) begin
      check("illegal_no_req", mem_req, 0);
      check("illegal_count", count, exp_count);
      check("illegal_ready", in_ready, 1);
    end else begin
      check("req_latency", mem_req, 1);
      check("busy_not_ready", in_ready, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;

    // Directed words with ack tied high
    ack_mode = 0;
    send(0, 1, 2, 3, 0, 0, 0, 64'h00221820);
    check("count_after_add", count, 1);
    check("addr_after_add", mem_addr, 1);
    send(6, 0, 8, 0, 0, 16'hFFFF, 0, 64'h2008FFFF);
    send(18, 0, 0, 0, 0, 0, 26'h10, 64'h08000010);
    send(19, 0, 0, 0, 0, 0, 26'h10, 64'h0C000010);
    send(3, 5, 2, 4, 3, 0, 0, 64'h000220C0);
    send(5, 31, 7, 9, 11, 0, 0, 64'h03E00008);

    // Ack withheld for several cycles
    ack_mode = 2;
    man_ack  = 1'b0;
    send(1, 4, 5, 6, 7, 0, 0, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req", mem_req, 1);
      check("stall_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    man_ack = 1'b1;
    @(posedge clk); #1;
    man_ack = 1'b0;
    @(negedge clk);
    check("stall_release_req", mem_req, 0);
    check("stall_release_addr", mem_addr, exp_addr);
    check("stall_release_count", count, exp_count);
    @(posedge clk); #1;

    // Fill to DEPTH, then extra requests while full are refused
    ack_mode = 0;
    wait_drain();
    do_clear();
    for (int i = 0; i < 4; i++) send(0, i, i + 1, i + 2, 0, 0, 0, -1);
    expect_full();
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("full_no_req", mem_req, 0);
    check("full_count_hold", count, DEPTH);
    check("full_addr_hold", mem_addr, DEPTH);
    @(posedge clk); #1;
    do_clear();

    // Illegal operation
    send(25, 1, 2, 3, 4, 5, 6, -1);
    send(9, 3, 4, 0, 0, 16'h1234, 0, -1);
    wait_drain();
    check("err_sticky", err, 1);
    do_clear();

    // Reset abandons a pending write
    ack_mode = 2;
    man_ack  = 1'b0;
    send(12, 29, 8, 0, 0, 16'h0040, 0, -1);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 1'b0;
    @(negedge clk);
    check("rreq_req", mem_req, 0);
    check("rreq_ready", in_ready, 1);
    check("rreq_addr", mem_addr, 0);
    check("rreq_wdata", mem_wdata, 0);
    check("rreq_count", count, 0);
    check("rreq_full", full, 0);
    check("rreq_err", err, 0);
    @(posedge clk); #1;

    // Random operations with random ack
    ack_mode = 1;
    for (int i = 0; i < 80; i++) begin
      send(int'($urandom_range(0, 21)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 65535)), int'($urandom & 32'h03FF_FFFF), -1);
    end
    wait_drain();
    check("final_count", count, exp_count);
    check("final_err", err, exp_err);
    check("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
